apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 146 ++++++++++++++
 tb/tb_apb_master.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB requester bridging a valid/ready command/response pair onto an APB bus
// Single outstanding transfer; ACCESS is bounded by timeoutCycles and aborts with rsp_timeout.
module apb_master #(
  parameter int addrWidth     = 2,
  parameter int dataWidth     = 8,
  parameter int timeoutCycles = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [dataWidth-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic                 sel,
  output logic                 enable,
  output logic                 write,
  output logic [addrWidth-1:0] addr,
  output logic [dataWidth-1:0] wdata,
  input  logic [dataWidth-1:0] rdata,
  input  logic                 ready,
  input  logic                 slverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [7:0] TIMEOUT = 8'(timeoutCycles);

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 sel_q, sel_d;
  logic                 enable_q, enable_d;
  logic                 write_q, write_d;
  logic [addrWidth-1:0] addr_q, addr_d;
  logic [dataWidth-1:0] wdata_q, wdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [dataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 rsp_timeout_q, rsp_timeout_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = cmd_ready_q;
    sel_d         = sel_q;
    enable_d      = enable_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d     = SETUP;
          cmd_ready_d = 1'b0;
          sel_d       = 1'b1;
          write_d     = cmd_write;
          addr_d      = cmd_addr;
          wdata_d     = cmd_write ? cmd_wdata : '0;
        end
      end
      SETUP: begin
        state_d  = ACCESS;
        enable_d = 1'b1;
        cnt_d    = 8'd1;
      end
      ACCESS: begin
        // ready on the final counted edge still completes normally
        if (ready || cnt_q == TIMEOUT) begin
          state_d       = RESP;
          sel_d         = 1'b0;
          enable_d      = 1'b0;
          cnt_d         = 8'd0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = (ready && !write_q) ? rdata : '0;
          rsp_err_d     = ready ? slverr : 1'b1;
          rsp_timeout_d = !ready;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d       = IDLE;
          cmd_ready_d   = 1'b1;
          rsp_valid_d   = 1'b0;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      cmd_ready_q   <= 1'b1;
      sel_q         <= 1'b0;
      enable_q      <= 1'b0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      sel_q         <= sel_d;
      enable_q      <= enable_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign sel         = sel_q;
  assign enable      = enable_q;
  assign write       = write_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed scoreboard bench for apb_master
module tb_apb_master;

  localparam int TO = 16;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
    logic       tmo;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_write, rsp_ready, ready, slverr;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata, rdata;
  logic       cmd_ready, rsp_valid, rsp_err, rsp_timeout, sel, enable, write;
  logic [7:0] rsp_rdata, wdata;
  logic [1:0] addr;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  apb_master #(.addrWidth(2), .dataWidth(8), .timeoutCycles(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .sel(sel), .enable(enable), .write(write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .slverr(slverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic wr, input logic [1:0] a, input logic [7:0] wd,
                         input int waits, input logic [7:0] rd, input logic sl,
                         input logic never, input int hold);
    exp_t e;
    exp_t got;
    int   acc;
    e.rdata = (wr || never) ? 8'h00 : rd;
    e.err   = never ? 1'b1 : sl;
    e.tmo   = never;
    sb.push_back(e);

    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_wdata = ~wd; cmd_addr = ~a; cmd_write = ~wr;
    chk("setup_sel", 32'(sel), 32'd1);
    chk("setup_enable", 32'(enable), 32'd0);
    chk("setup_write", 32'(write), 32'(wr));
    chk("setup_addr", 32'(addr), 32'(a));
    chk("setup_wdata", 32'(wdata), wr ? 32'(wd) : 32'd0);
    chk("setup_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);

    acc = 0;
    for (int g = 0; g < 40; g++) begin
      if (!(sel && enable)) break;
      acc++;
      chk("access_addr", 32'(addr), 32'(a));
      chk("access_write", 32'(write), 32'(wr));
      ready  = !never && (acc == waits + 1);
      rdata  = rd;
      slverr = sl;
      @(negedge clk);
      ready = 1'b0; slverr = 1'b1; rdata = 8'hEE;
    end
    chk("access_cycles", 32'(acc), never ? 32'(TO) : 32'(waits + 1));
    chk("resp_sel", 32'(sel), 32'd0);
    chk("resp_enable", 32'(enable), 32'd0);
    chk("resp_valid", 32'(rsp_valid), 32'd1);
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk("rsp_rdata", 32'(rsp_rdata), 32'(got.rdata));
      chk("rsp_err", 32'(rsp_err), 32'(got.err));
      chk("rsp_timeout", 32'(rsp_timeout), 32'(got.tmo));
    end

    cmd_valid = (hold > 0);
    cmd_write = 1'b1; cmd_addr = 2'd3; cmd_wdata = 8'h99;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", 32'(rsp_rdata), 32'(e.rdata));
      chk("hold_err", 32'(rsp_err), 32'(e.err));
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold_sel", 32'(sel), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("done_valid", 32'(rsp_valid), 32'd0);
    chk("done_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("done_no_setup", 32'(sel), 32'd0);
    cmd_valid = 1'b0;
    slverr = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 2'd0; cmd_wdata = 8'd0;
    rsp_ready = 1'b0; ready = 1'b0; slverr = 1'b0; rdata = 8'd0;
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_txn(1'b1, 2'd1, 8'd25, 0, 8'h00, 1'b0, 1'b0, 0);
    run_txn(1'b0, 2'd2, 8'hAA, 3, 8'h17, 1'b0, 1'b0, 0);
    run_txn(1'b0, 2'd3, 8'h00, 0, 8'h6C, 1'b1, 1'b0, 0);
    run_txn(1'b0, 2'd1, 8'h00, 0, 8'h42, 1'b0, 1'b1, 0);
    run_txn(1'b0, 2'd0, 8'h00, TO - 1, 8'h5A, 1'b0, 1'b0, 0);
    run_txn(1'b1, 2'd0, 8'hC3, 0, 8'h33, 1'b0, 1'b0, 5);

    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd2; cmd_wdata = 8'h00;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_access_enable", 32'(enable), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_sel", 32'(sel), 32'd0);
    chk("abort_enable", 32'(enable), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_addr", 32'(addr), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    chk("abort_sb_empty", 32'(sb.size()), 32'd0);
    run_txn(1'b0, 2'd1, 8'h00, 1, 8'h81, 1'b0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
